trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_sequencer.sv | 129 ++++++++++++
 tb/tb_trigger_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// Trigger sequencer for a circular capture buffer: pre-trigger fill, armed
// wrap-around capture, trigger-address latch and post-trigger completion.
module trigger_sequencer #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              adc_clk,
    input  logic              adc_rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_in,
    input  logic              trig_sw,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t            state;
    logic              trig_prev;
    logic [ADDR_W-1:0] pre_len_q;
    logic [ADDR_W-1:0] post_len_q;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic              trig_evt_c;
    logic              pre_last_c;
    logic              post_last_c;

    // Rising edge of the comparator level, or a software force.
    assign trig_evt_c  = (trig_in & ~trig_prev) | trig_sw;
    assign pre_last_c  = (pre_cnt == pre_len_q - ADDR_W'(1));
    assign post_last_c = (post_cnt == post_len_q - ADDR_W'(1));

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state      <= S_IDLE;
            trig_prev  <= 1'b1;
            pre_len_q  <= '0;
            post_len_q <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            trig_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            trig_prev <= trig_in;

            // Every issued write advances the address; arm overrides below.
            if (buf_we) begin
                buf_addr <= buf_addr + ADDR_W'(1);
            end

            if (abort) begin
                state  <= S_IDLE;
                buf_we <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            pre_len_q  <= pre_len;
                            post_len_q <= post_len;
                            pre_cnt    <= '0;
                            post_cnt   <= '0;
                            buf_addr   <= '0;
                            buf_we     <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            state      <= (pre_len == '0) ? S_ARMED : S_PRE;
                        end
                    end

                    S_PRE: begin
                        pre_cnt <= pre_cnt + ADDR_W'(1);
                        if (pre_last_c) begin
                            state <= S_ARMED;
                        end
                    end

                    // The write issued in the trigger cycle is the trigger sample.
                    S_ARMED: begin
                        if (trig_evt_c) begin
                            trig_addr <= buf_addr;
                            if (post_len_q == '0) begin
                                state  <= S_DONE;
                                buf_we <= 1'b0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end

                    S_POST: begin
                        post_cnt <= post_cnt + ADDR_W'(1);
                        if (post_last_c) begin
                            state  <= S_DONE;
                            buf_we <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end

                    default: begin
                        state  <= S_IDLE;
                        buf_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with a 16-entry buffer (ADDR_W=4):
// table-driven basic capture plus hand-written multi-cycle corner sequences.
module tb_trigger_sequencer;

    localparam int unsigned AW = 4;

    logic          adc_clk = 1'b0;
    logic          adc_rst;
    logic          arm;
    logic          abort;
    logic          trig_in;
    logic          trig_sw;
    logic [AW-1:0] pre_len;
    logic [AW-1:0] post_len;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_base;

    trigger_sequencer #(.ADDR_W(AW)) dut (
        .adc_clk  (adc_clk),
        .adc_rst  (adc_rst),
        .arm      (arm),
        .abort    (abort),
        .trig_in  (trig_in),
        .trig_sw  (trig_sw),
        .pre_len  (pre_len),
        .post_len (post_len),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .trig_addr(trig_addr),
        .busy     (busy),
        .done     (done)
    );

    always #5 adc_clk = ~adc_clk;

    // Count buffer writes actually issued.
    always @(posedge adc_clk) begin
        if (buf_we === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        logic          arm;
        logic          tin;
        logic          tsw;
        logic          we;
        logic [AW-1:0] addr;
        logic [AW-1:0] ta;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic a, ti, ts, we, input int addr, ta,
                                input logic b, d);
        vec_t v;
        v.arm = a; v.tin = ti; v.tsw = ts; v.we = we;
        v.addr = AW'(addr); v.ta = AW'(ta); v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic step(input logic a, ab, ti, ts);
        arm = a; abort = ab; trig_in = ti; trig_sw = ts;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string name, input logic we_e, input logic [AW-1:0] addr_e,
                         input logic [AW-1:0] ta_e, input logic busy_e, done_e);
        logic [2*AW+2:0] act;
        logic [2*AW+2:0] exp;
        act = {buf_we, buf_addr, trig_addr, busy, done};
        exp = {we_e, addr_e, ta_e, busy_e, done_e};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%0d trig=%0d busy=%b done=%b, want we=%b addr=%0d trig=%0d busy=%b done=%b",
                     name, buf_we, buf_addr, trig_addr, busy, done,
                     we_e, addr_e, ta_e, busy_e, done_e);
        end
    endtask

    task automatic check_wr(input string name, input int exp);
        n_tests++;
        if (wr_cnt - wr_base != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d writes, want %0d", name, wr_cnt - wr_base, exp);
        end
    endtask

    initial begin
        adc_rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0; trig_sw = 1'b0;
        pre_len = '0; post_len = '0;

        // Reset, including arm ignored while reset is held
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_hold", 0, 0, 0, 0, 0);
        adc_rst = 1'b0;
        step(0, 0, 0, 0);
        check("rst_release", 0, 0, 0, 0, 0);

        // A: pre=4 post=3, trig_in rises to trigger at addr 10
        vecs[0] = mk(1, 0, 0, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) vecs[k] = mk(0, 0, 0, 1, k, 0, 1, 0);
        vecs[11] = mk(0, 1, 0, 1, 11, 10, 1, 0);
        vecs[12] = mk(0, 1, 0, 1, 12, 10, 1, 0);
        vecs[13] = mk(0, 1, 0, 1, 13, 10, 1, 0);
        vecs[14] = mk(0, 1, 0, 0, 14, 10, 0, 1);
        vecs[15] = mk(0, 1, 1, 0, 14, 10, 0, 1);
        pre_len = AW'(4); post_len = AW'(3);
        wr_base = wr_cnt;
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].arm, 0, vecs[i].tin, vecs[i].tsw);
            check($sformatf("A_vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].ta,
                  vecs[i].busy, vecs[i].done);
        end
        check_wr("A_writes", 14);

        // B1: trig_in high through arm/PRE, triggers only on fall and re-rise
        pre_len = AW'(2); post_len = AW'(1);
        wr_base = wr_cnt;
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("B1_held_high", 1, 4, 10, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("B1_rerise", 1, 6, 5, 1, 0);
        step(0, 0, 1, 0);
        check("B1_done", 0, 7, 5, 0, 1);
        check_wr("B1_writes", 7);

        // B2: trig_sw ignored in PRE, immediate in first ARMED cycle
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("B2_sw_in_pre", 1, 1, 5, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("B2_sw_armed", 1, 3, 2, 1, 0);
        step(0, 0, 0, 0);
        check("B2_done", 0, 4, 2, 0, 1);

        // C: pre=0 post=0, single write at addr 0
        pre_len = '0; post_len = '0;
        wr_base = wr_cnt;
        step(1, 0, 0, 0);
        check("C_armed", 1, 0, 2, 1, 0);
        step(0, 0, 0, 1);
        check("C_done", 0, 1, 0, 0, 1);
        check_wr("C_writes", 1);

        // D: pre=2, 20 armed cycles wrap the address, trigger at (2+20) mod 16
        pre_len = AW'(2); post_len = AW'(1);
        wr_base = wr_cnt;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 3; k <= 22; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("D_armed%0d", k), 1, AW'(k), 0, 1, 0);
        end
        step(0, 0, 0, 1);
        check("D_trig", 1, 7, 6, 1, 0);
        step(0, 0, 0, 0);
        check("D_done", 0, 8, 6, 0, 1);
        check_wr("D_writes", 24);

        // E: arm ignored in PRE; abort beats arm in POST; re-arm restarts at 0
        pre_len = AW'(1); post_len = AW'(5);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("E_arm_ignored", 1, 1, 6, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("E_post", 1, 3, 1, 1, 0);
        step(1, 1, 0, 0);
        check("E_abort", 0, 4, 1, 0, 0);
        step(0, 0, 0, 1);
        check("E_idle_hold", 0, 4, 1, 0, 0);
        pre_len = AW'(3); post_len = AW'(2);
        step(1, 0, 0, 0);
        check("E_rearm", 1, 0, 1, 1, 0);

        // F: reset in ARMED with trig_in rising; no spurious trigger afterwards
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("F_armed", 1, 4, 1, 1, 0);
        adc_rst = 1'b1;
        step(0, 0, 1, 0);
        check("F_rst", 0, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        adc_rst = 1'b0;
        step(0, 0, 1, 0);
        check("F_rst_release", 0, 0, 0, 0, 0);
        pre_len = '0; post_len = AW'(2);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("F_no_spurious", 1, 2, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("F_trig", 1, 4, 3, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("F_done", 0, 6, 3, 0, 1);
        step(0, 1, 1, 0);
        check("F_abort_done", 0, 6, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
